// File: rtl/gals_pkg.sv
// Shared definitions for the GALS producer/consumer pair.
//   state_t            : producer FSM encoding (IDLE=0, SEND=1, HOLD=2, FINISH=3)
//   LFSR_TAPS          : feedback mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   DEFAULT_LFSR_SEED  : substitute seed when an all-zero seed would lock the LFSR
//   next_pattern()     : advances the data pattern one step
//   burst_seed()       : first word of a burst for the selected mode
package gals_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // Bits 15,13,12,10 of the current word feed the new LSB.
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;

  function automatic logic [15:0] next_pattern(input logic [15:0] p, input logic lfsr);
    if (lfsr) return {p[14:0], ^(p & LFSR_TAPS)};
    return p + 16'd1;
  endfunction

  // An all-zero LFSR state never leaves zero, so it is replaced.
  function automatic logic [15:0] burst_seed(input logic [15:0] seed, input logic lfsr);
    return (lfsr && (seed == 16'h0000)) ? DEFAULT_LFSR_SEED : seed;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level signal.
//   clock  in  destination-domain clock
//   reset  in  synchronous, active-high; clears every stage
//   d      in  asynchronous level
//   q      out level after STAGES flops
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: clocked state uses non-blocking assignments so every stage samples the
  // previous stage's old value on the same edge; blocking would collapse the chain.
  always_ff @(posedge clock) begin
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/gals_producer.sv
// Source end of the GALS producer/consumer buffer: emits a burst of 16-bit words
// (incrementing or LFSR pattern) and throttles on the synchronised buffer_full flag.
//   clock        in   write-side clock
//   reset        in   synchronous, active-high
//   start        in   pulse; begins a burst, sampled only in IDLE
//   mode         in   0 = incrementing, 1 = LFSR; latched on start
//   word_count   in   words in burst, latched on start; 0 = empty burst
//   buffer_full  in   buffer full flag, asynchronous to clock
//   data_1       out  registered write data
//   data_1_en    out  registered write strobe, one word per high cycle
//   busy         out  high in SEND/HOLD/FINISH
//   done         out  one-cycle pulse at burst end
//   sent_count   out  words issued in current/last burst
module gals_producer
  import gals_pkg::*;
#(
  parameter logic [15:0] SEED        = 16'h0001,
  parameter int          CNT_W       = 8,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] word_count,
  input  logic             buffer_full,
  output logic [15:0]      data_1,
  output logic             data_1_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_count
);

  state_t           state, state_next;
  logic             full_s;
  logic             issue;
  logic             arm;
  logic             mode_q;
  logic [15:0]      pattern;
  logic [CNT_W-1:0] remaining;

  sync_ff #(.STAGES(SYNC_STAGES)) u_full_sync (
    .clock (clock),
    .reset (reset),
    .d     (buffer_full),
    .q     (full_s)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = (word_count == '0) ? ST_FINISH : ST_SEND;
      end
      ST_SEND, ST_HOLD: begin
        // The first cycle after start only arms the burst; words begin the cycle after.
        issue = !full_s && (remaining != '0) && !arm;
        if (issue && (remaining == CNT_W'(1))) state_next = ST_FINISH;
        else                                   state_next = full_s ? ST_HOLD : ST_SEND;
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_1     <= '0;
      data_1_en  <= 1'b0;
      done       <= 1'b0;
      sent_count <= '0;
      remaining  <= '0;
      pattern    <= SEED;
      mode_q     <= 1'b0;
      arm        <= 1'b0;
    end else begin
      data_1_en <= issue;
      done      <= (state == ST_FINISH);
      arm       <= (state == ST_IDLE) && start;
      if ((state == ST_IDLE) && start) begin
        mode_q     <= mode;
        remaining  <= word_count;
        pattern    <= burst_seed(SEED, mode);
        sent_count <= '0;
      end
      if (issue) begin
        data_1     <= pattern;
        pattern    <= next_pattern(pattern, mode_q);
        remaining  <= remaining - 1'b1;
        sent_count <= sent_count + 1'b1;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
